// File: rtl/fazyrv_rf_pkg.sv
// Shared definitions for the FazyRV register-file access sequencer.
// Latency: n/a (types, constants and helper functions only).
// Backpressure: n/a.
//
// Contents: sequencer state enum, beat-count helper, legal chunk-size check.

package fazyrv_rf_pkg;

   typedef enum logic [2:0] {
      IDLE,
      READ,
      LOAD,
      SHIFT,
      WRITE
   } rf_seq_state_t;

   // Number of CHUNKSIZE-wide beats needed to move one register word.
   function automatic int rf_nbeat(input int regw, input int chunksize);
      return regw / chunksize;
   endfunction

   // The datapath supports 1, 2, 4 or 8 bits per beat, and the register
   // word must split into a whole number of beats.
   function automatic bit rf_chunk_legal(input int chunksize, input int regw);
      return ((chunksize == 1) || (chunksize == 2) || (chunksize == 4) ||
              (chunksize == 8)) && ((regw % chunksize) == 0);
   endfunction

endpackage

// File: rtl/fazyrv_rf_shreg.sv
// REGW-bit shift register with parallel load and CHUNKSIZE-bit right shift.
// Latency: load or shift takes effect on the next rising edge.
// Backpressure: none; the owner decides when to load or shift.
//
// Ports: i_clk, i_rst_n (sync, active-low), i_ld/i_ld_dat parallel load,
//        i_shift/i_shift_in right shift with new bits entering at the MSB,
//        o_q current register contents.

module fazyrv_rf_shreg
   import fazyrv_rf_pkg::*;
#(
   parameter int REGW      = 32,
   parameter int CHUNKSIZE = 8
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic                 i_ld,
   input  logic [REGW-1:0]      i_ld_dat,
   input  logic                 i_shift,
   input  logic [CHUNKSIZE-1:0] i_shift_in,
   output logic [REGW-1:0]      o_q
);

   logic [REGW-1:0] r_q;

   // Load wins over shift; the sequencer never asserts both together.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_q <= '0;
      end else if (i_ld) begin
         r_q <= i_ld_dat;
      end else if (i_shift) begin
         r_q <= {i_shift_in, r_q[REGW-1:CHUNKSIZE]};
      end
   end

   assign o_q = r_q;

endmodule

// File: rtl/fazyrv_rf_seq.sv
// Register-file sequencer: reads rs from the single-port RAM, streams it LSB
//   first in CHUNKSIZE beats while collecting rd chunks, then writes rd back.
// Latency: first beat 3 cycles after start; WRITE/done_o at 3+NBEAT (+stalls).
// Backpressure: chunk_rdy_i low in SHIFT freezes data, counter and state.
//
// Ports: clk_i, rst_in (sync, active-low); start_i/rs_adr_i/rd_adr_i/rd_we_i
//        request; chunk_vld_o/chunk_rdy_i/rs_chunk_o/rd_chunk_i beat stream;
//        busy_o, done_o status; ram_* registered RAM request and read data.
// Optional feature: define FAZYRV_RF_X0_GUARD_EN to make x0 read as zero and
//        suppress writes to x0 inside this block.

module fazyrv_rf_seq
   import fazyrv_rf_pkg::*;
#(
   parameter int CHUNKSIZE = 8,
   parameter int REGW      = 32,
   parameter int ADRW      = 5
) (
   input  logic                 clk_i,
   input  logic                 rst_in,
   input  logic                 start_i,
   input  logic [ADRW-1:0]      rs_adr_i,
   input  logic [ADRW-1:0]      rd_adr_i,
   input  logic                 rd_we_i,
   output logic                 chunk_vld_o,
   input  logic                 chunk_rdy_i,
   output logic [CHUNKSIZE-1:0] rs_chunk_o,
   input  logic [CHUNKSIZE-1:0] rd_chunk_i,
   output logic                 busy_o,
   output logic                 done_o,
   output logic                 ram_we_o,
   output logic [ADRW-1:0]      ram_waddr_o,
   output logic [ADRW-1:0]      ram_raddr_o,
   output logic [REGW-1:0]      ram_wdata_o,
   input  logic [REGW-1:0]      ram_rdata_i
);

   localparam int NBEAT = rf_nbeat(REGW, CHUNKSIZE);
   localparam int CNTW  = (NBEAT > 1) ? $clog2(NBEAT) : 1;

   generate
      if (!rf_chunk_legal(CHUNKSIZE, REGW)) begin : g_bad_chunksize
         $error("fazyrv_rf_seq: CHUNKSIZE must be 1, 2, 4 or 8 and divide REGW");
      end
   endgenerate

   rf_seq_state_t   r_state;
   rf_seq_state_t   w_state_nxt;

   logic [ADRW-1:0] r_rs_adr;
   logic [ADRW-1:0] r_rd_adr;
   logic            r_rd_we;
   logic            r_ram_we;
   logic [CNTW-1:0] r_cnt;

   logic            w_start;
   logic            w_load;
   logic            w_vld;
   logic            w_beat;
   logic            w_we_nxt;
   logic [REGW-1:0] w_ld_dat;
   logic [REGW-1:0] w_rd_q;
   logic [REGW-1:0] w_wr_q;
   logic            w_unused_rd_hi;

   // ---------------------------------------------------------------------
   // FSM
   // ---------------------------------------------------------------------
   always_ff @(posedge clk_i) begin
      if (!rst_in) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_start     = 1'b0;
      w_load      = 1'b0;
      w_vld       = 1'b0;
      case (r_state)
         IDLE: begin
            if (start_i) begin
               w_start     = 1'b1;
               w_state_nxt = READ;
            end
         end
         // RAM samples ram_raddr_o during this cycle.
         READ:  w_state_nxt = LOAD;
         LOAD: begin
            w_load      = 1'b1;
            w_state_nxt = SHIFT;
         end
         SHIFT: begin
            w_vld = 1'b1;
            if (chunk_rdy_i && (r_cnt == '0)) begin
               w_state_nxt = WRITE;
            end
         end
         WRITE:   w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   assign w_beat = w_vld & chunk_rdy_i;

   // ---------------------------------------------------------------------
   // x0 handling
   // ---------------------------------------------------------------------
`ifdef FAZYRV_RF_X0_GUARD_EN
   assign w_ld_dat = (r_rs_adr == '0) ? '0 : ram_rdata_i;
   assign w_we_nxt = (w_state_nxt == WRITE) && r_rd_we && (r_rd_adr != '0);
`else
   assign w_ld_dat = ram_rdata_i;
   assign w_we_nxt = (w_state_nxt == WRITE) && r_rd_we;
`endif

   // ---------------------------------------------------------------------
   // Request latch, beat counter, registered write enable
   // ---------------------------------------------------------------------
   // ram_we_o is computed one cycle early from the next state so that it is
   // a plain flop that is high exactly during WRITE; a sync reset clears it
   // on the same edge that forces the FSM back to IDLE.
   always_ff @(posedge clk_i) begin
      if (!rst_in) begin
         r_rs_adr <= '0;
         r_rd_adr <= '0;
         r_rd_we  <= 1'b0;
         r_ram_we <= 1'b0;
         r_cnt    <= '0;
      end else begin
         if (w_start) begin
            r_rs_adr <= rs_adr_i;
            r_rd_adr <= rd_adr_i;
            r_rd_we  <= rd_we_i;
         end
         if (w_load) begin
            r_cnt <= CNTW'(NBEAT - 1);
         end else if (w_beat) begin
            r_cnt <= r_cnt - CNTW'(1);
         end
         r_ram_we <= w_we_nxt;
      end
   end

   // ---------------------------------------------------------------------
   // Source and result shift registers
   // ---------------------------------------------------------------------
   fazyrv_rf_shreg #(
      .REGW      (REGW),
      .CHUNKSIZE (CHUNKSIZE)
   ) u_rd_shreg (
      .i_clk      (clk_i),
      .i_rst_n    (rst_in),
      .i_ld       (w_load),
      .i_ld_dat   (w_ld_dat),
      .i_shift    (w_beat),
      .i_shift_in ({CHUNKSIZE{1'b0}}),
      .o_q        (w_rd_q)
   );

   // Cleared in LOAD so a transfer never carries bits from the previous one;
   // after NBEAT beats every bit has been replaced by a result chunk anyway.
   fazyrv_rf_shreg #(
      .REGW      (REGW),
      .CHUNKSIZE (CHUNKSIZE)
   ) u_wr_shreg (
      .i_clk      (clk_i),
      .i_rst_n    (rst_in),
      .i_ld       (w_load),
      .i_ld_dat   ({REGW{1'b0}}),
      .i_shift    (w_beat),
      .i_shift_in (rd_chunk_i),
      .o_q        (w_wr_q)
   );

   // Only the low chunk of the source register is visible to the datapath.
   assign w_unused_rd_hi = ^w_rd_q[REGW-1:CHUNKSIZE];

   // ---------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------
   assign chunk_vld_o = w_vld;
   assign rs_chunk_o  = w_rd_q[CHUNKSIZE-1:0];
   assign busy_o      = (r_state != IDLE);
   assign done_o      = (r_state == WRITE);
   assign ram_we_o    = r_ram_we;
   assign ram_waddr_o = r_rd_adr;
   assign ram_raddr_o = r_rs_adr;
   assign ram_wdata_o = w_wr_q;

endmodule

// File: tb/tb_fazyrv_rf_seq.sv
// Self-checking bench for fazyrv_rf_seq with a behavioural RAM and a
// word-level reference model (expected stream, write word and timing).
// Honours FAZYRV_RF_X0_GUARD_EN when computing expectations.

module tb_fazyrv_rf_seq;

   localparam int CS = 8;
   localparam int RW = 32;
   localparam int AW = 5;
   localparam int NB = RW / CS;

`ifdef FAZYRV_RF_X0_GUARD_EN
   localparam bit GUARD = 1'b1;
`else
   localparam bit GUARD = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst_in;
   logic          start_i;
   logic [AW-1:0] rs_adr_i;
   logic [AW-1:0] rd_adr_i;
   logic          rd_we_i;
   logic          chunk_vld_o;
   logic          chunk_rdy_i;
   logic [CS-1:0] rs_chunk_o;
   logic [CS-1:0] rd_chunk_i;
   logic          busy_o;
   logic          done_o;
   logic          ram_we_o;
   logic [AW-1:0] ram_waddr_o;
   logic [AW-1:0] ram_raddr_o;
   logic [RW-1:0] ram_wdata_o;
   logic [RW-1:0] ram_rdata_i;

   always #5 clk = ~clk;

   fazyrv_rf_seq #(
      .CHUNKSIZE (CS),
      .REGW      (RW),
      .ADRW      (AW)
   ) dut (
      .clk_i       (clk),
      .rst_in      (rst_in),
      .start_i     (start_i),
      .rs_adr_i    (rs_adr_i),
      .rd_adr_i    (rd_adr_i),
      .rd_we_i     (rd_we_i),
      .chunk_vld_o (chunk_vld_o),
      .chunk_rdy_i (chunk_rdy_i),
      .rs_chunk_o  (rs_chunk_o),
      .rd_chunk_i  (rd_chunk_i),
      .busy_o      (busy_o),
      .done_o      (done_o),
      .ram_we_o    (ram_we_o),
      .ram_waddr_o (ram_waddr_o),
      .ram_raddr_o (ram_raddr_o),
      .ram_wdata_o (ram_wdata_o),
      .ram_rdata_i (ram_rdata_i)
   );

   // Single-port RAM: write when we is high, else registered read.
   // poke_* lets the bench preload contents while the DUT is idle.
   logic [RW-1:0] mem [32];
   logic          poke_vld;
   logic [AW-1:0] poke_adr;
   logic [RW-1:0] poke_dat;

   always @(posedge clk) begin
      if (poke_vld) begin
         mem[poke_adr] <= poke_dat;
      end else if (ram_we_o) begin
         mem[ram_waddr_o] <= ram_wdata_o;
      end
      if (!ram_we_o) begin
         ram_rdata_i <= mem[ram_raddr_o];
      end
   end

   // Reference register contents as the architecture should see them.
   logic [RW-1:0] ref_mem [32];

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic poke(input logic [AW-1:0] adr, input logic [RW-1:0] dat);
      poke_vld = 1'b1;
      poke_adr = adr;
      poke_dat = dat;
      step();
      poke_vld     = 1'b0;
      ref_mem[adr] = dat;
   endtask

   // One full transfer. Called at cycle 0 (just after an edge, DUT idle).
   // stall_at/stall_len force rdy low before beat stall_at; stall_pct adds
   // random stalls; noise pulses start_i during SHIFT.
   task automatic xfer(input logic [AW-1:0] rs, input logic [AW-1:0] rd, input logic we,
                       input logic [RW-1:0] wr_word, input int stall_at, input int stall_len,
                       input int stall_pct, input bit noise);
      logic [RW-1:0] src;
      logic          exp_we;
      int            b;
      int            stalls;
      int            forced;
      int            cyc;
      bit            hold;
      src    = (GUARD && rs == '0) ? '0 : ref_mem[rs];
      exp_we = we && !(GUARD && rd == '0);

      start_i     = 1'b1;
      rs_adr_i    = rs;
      rd_adr_i    = rd;
      rd_we_i     = we;
      chunk_rdy_i = 1'b0;
      step();
      // cycle 1: READ; inputs scrambled to prove they were latched
      start_i  = 1'b0;
      rs_adr_i = AW'($urandom_range(0, 31));
      rd_adr_i = AW'($urandom_range(0, 31));
      rd_we_i  = ~we;
      chk("read_busy", busy_o, 1);
      chk("read_vld", chunk_vld_o, 0);
      chk("read_raddr", ram_raddr_o, rs);
      chk("read_we", ram_we_o, 0);
      step();
      // cycle 2: LOAD
      chk("load_vld", chunk_vld_o, 0);
      chk("load_busy", busy_o, 1);
      step();
      cyc    = 3;
      b      = 0;
      stalls = 0;
      forced = stall_len;
      while (b < NB && cyc < 200) begin
         chk("beat_vld", chunk_vld_o, 1);
         chk("beat_chunk", rs_chunk_o, src[CS*b +: CS]);
         chk("beat_we", ram_we_o, 0);
         chk("beat_done", done_o, 0);
         start_i = noise && ($urandom_range(0, 3) == 0);
         hold    = (b == stall_at && forced > 0) || (int'($urandom_range(0, 99)) < stall_pct);
         if (hold) begin
            chunk_rdy_i = 1'b0;
            rd_chunk_i  = CS'($urandom);
            if (b == stall_at && forced > 0) forced--;
            stalls++;
         end else begin
            chunk_rdy_i = 1'b1;
            rd_chunk_i  = wr_word[CS*b +: CS];
            b++;
         end
         step();
         cyc++;
      end
      chk("beats_done", b, NB);
      // WRITE cycle
      start_i     = 1'b0;
      chunk_rdy_i = 1'b0;
      chk("write_cycle", cyc, 3 + NB + stalls);
      chk("write_done", done_o, 1);
      chk("write_busy", busy_o, 1);
      chk("write_vld", chunk_vld_o, 0);
      chk("write_we", ram_we_o, exp_we);
      chk("write_addr", ram_waddr_o, rd);
      chk("write_data", ram_wdata_o, wr_word);
      if (exp_we) ref_mem[rd] = wr_word;
      step();
      chk("idle_busy", busy_o, 0);
      chk("idle_done", done_o, 0);
      chk("idle_we", ram_we_o, 0);
   endtask

   // Transfer cut short by reset during beat k (rdy high, so beat k would
   // otherwise be accepted). No write may follow.
   task automatic rst_xfer(input logic [AW-1:0] rs, input logic [AW-1:0] rd, input int k);
      start_i     = 1'b1;
      rs_adr_i    = rs;
      rd_adr_i    = rd;
      rd_we_i     = 1'b1;
      chunk_rdy_i = 1'b0;
      step();
      start_i = 1'b0;
      step();
      step();
      for (int i = 0; i < k; i++) begin
         chunk_rdy_i = 1'b1;
         rd_chunk_i  = CS'($urandom);
         step();
      end
      rst_in      = 1'b0;
      chunk_rdy_i = 1'b1;
      rd_chunk_i  = CS'($urandom);
      step();
      chk("rst_busy", busy_o, 0);
      chk("rst_vld", chunk_vld_o, 0);
      chk("rst_done", done_o, 0);
      chk("rst_we", ram_we_o, 0);
      rst_in      = 1'b1;
      chunk_rdy_i = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("rst_after_we", ram_we_o, 0);
         chk("rst_after_busy", busy_o, 0);
      end
   endtask

   initial begin
      rst_in      = 1'b0;
      start_i     = 1'b0;
      rs_adr_i    = '0;
      rd_adr_i    = '0;
      rd_we_i     = 1'b0;
      chunk_rdy_i = 1'b0;
      rd_chunk_i  = '0;
      poke_vld    = 1'b0;
      poke_adr    = '0;
      poke_dat    = '0;
      step();

      // Preload RAM while reset is held, then check reset values.
      for (int i = 0; i < 32; i++) begin
         poke(AW'(i), RW'($urandom));
      end
      chk("reset_busy", busy_o, 0);
      chk("reset_vld", chunk_vld_o, 0);
      chk("reset_done", done_o, 0);
      chk("reset_we", ram_we_o, 0);
      chk("reset_waddr", ram_waddr_o, 0);
      chk("reset_raddr", ram_raddr_o, 0);
      chk("reset_wdata", ram_wdata_o, 0);
      rst_in = 1'b1;
      step();

      // Basic read/write.
      poke(5'd3, 32'hA1B2C3D4);
      xfer(5'd3, 5'd5, 1'b1, 32'h44332211, -1, 0, 0, 1'b0);

      // Forced two-cycle stall after three beats.
      poke(5'd9, 32'h13579BDF);
      xfer(5'd9, 5'd10, 1'b1, 32'hCAFEF00D, 3, 2, 0, 1'b0);

      // No write-back.
      xfer(5'd4, 5'd6, 1'b0, 32'h0BADF00D, -1, 0, 0, 1'b0);

      // x0 source and destination.
      poke(5'd0, 32'hFFFFFFFF);
      xfer(5'd0, 5'd0, 1'b1, 32'h12345678, -1, 0, 0, 1'b0);

      // Reset mid-transfer (cycle 5) and on the final beat, then basic again.
      rst_xfer(5'd3, 5'd5, 2);
      rst_xfer(5'd3, 5'd5, NB - 1);
      xfer(5'd3, 5'd5, 1'b1, 32'h44332211, -1, 0, 0, 1'b0);

      // Back-to-back write then read of x7, with start noise during SHIFT.
      xfer(5'd1, 5'd7, 1'b1, 32'hDEADBEEF, -1, 0, 0, 1'b1);
      xfer(5'd7, 5'd8, 1'b1, 32'h00000000, -1, 0, 0, 1'b1);

      // Randomised transfers.
      for (int n = 0; n < 40; n++) begin
         xfer(AW'($urandom_range(0, 31)), AW'($urandom_range(0, 31)),
              1'($urandom_range(0, 1)), RW'($urandom),
              int'($urandom_range(0, NB - 1)), int'($urandom_range(0, 2)), 25, 1'b1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
